pe_acc_pipe: RTL and testbench
==============================

// Module: pe_acc_pipe
// PURPOSE
//  Pipelined, parametrised successor to the combinational PE add tree.
//  - Reduces NUM_LANES signed products per beat through a registered binary add tree.
//  - Accumulates beats across a dot-product group; the group ends on a beat with in_last.
//  - Emits one ACC_W result per group on a valid/ready output with full backpressure.
//  - Sits between the PE multiplier array and the output/writeback buffer.
// PARAMETERS
//  NUM_LANES  32  products per beat; power of two, >= 2
//  IN_W       32  width of each signed product lane
//  ACC_W      32  accumulator/result width; two's-complement wrap
//  LVL        $clog2(NUM_LANES)  tree levels (derived, not overridable)
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  synchronous reset, active-high
//  in_valid   in   1                  beat present on in_data
//  in_ready   out  1                  block can accept a beat this cycle
//  in_data    in   NUM_LANES*IN_W     lane j = in_data[IN_W*j+IN_W-1 -: IN_W], signed
//  in_last    in   1                  final beat of the current group
//  out_valid  out  1                  out_data holds a completed group sum
//  out_ready  in   1                  consumer accepts out_data
//  out_data   out  ACC_W              signed group sum
//  busy       out  1                  any beat in tree stages, or accumulator holds a partial group
// BEHAVIOUR
//  - Reset: the following clear on the first rising clk edge with rst=1.
//    - Clear: all stage valids, the accumulator, out_valid=0, out_data=0, busy=0.
//    - In flight: beats and partial groups are discarded.
//    - in_ready: driven 0 while rst=1.
//  - Stall: stall = out_valid & ~out_ready.
//    - in_ready = ~stall & ~rst.
//    - Transfer on in_valid & in_ready.
//    - While stall=1, every pipeline register (data, valid, last) holds its value.
//  - Tree:
//    - Level 0 sign-extends each lane to IN_W+LVL bits.
//    - Level k (1..LVL) registers the sums of adjacent pairs: node j = node 2j + node 2j+1.
//    - One register stage per level; each stage carries a valid bit and a last bit.
//    - No intermediate truncation occurs, so the tree never overflows.
//  - Accumulate (stage LVL+1), when the stage-LVL valid is set and stall=0:
//    - acc_next = acc + trunc_ACC_W(tree_sum) (sign-extend instead if ACC_W > IN_W+LVL), modulo 2^ACC_W.
//    - If last: out_data <= acc_next, out_valid <= 1, acc <= 0.
//    - Else: acc <= acc_next.
//  - Output:
//    - out_valid clears on out_valid & out_ready, unless a new last completes in that same cycle; then out_valid stays 1 with the new data.
//    - out_data is stable while out_valid & ~out_ready.
//  - Latency: no stall -> out_valid rises exactly LVL+1 cycles after the last beat is accepted (6 for defaults).
//  - Throughput: one beat per cycle; back-to-back groups, including single-beat groups, with no bubbles.
//  - Boundaries:
//    - A bubble (in_valid=0) between beats of a group does not disturb acc.
//    - A beat with in_last=1 and no preceding beats is a single-beat group.
//    - in_data and in_last are ignored when no transfer occurs.
// STRUCTURE
//  - pe_acc_pkg: function clog2; localparam defaults for NUM_LANES, IN_W, ACC_W; macro/function lane_slice(j).
//  - Sub-module pe_add_stage #(N_IN, W):
//    - One registered tree level: N_IN inputs -> N_IN/2 sums of width W+1.
//    - Carries valid and last; has an en input driven by ~stall.
//    - Instantiated LVL times in a generate loop.
//  - Top: lane unpack/sign-extend, stage chain, accumulator/output register, stall logic.
// TESTING
//  - T1 single beat: all lanes = 1, in_last=1 -> out_data=32, out_valid exactly 6 cycles later.
//  - T2 multi-beat group: 4 beats of lane j = j, last on beat 4 -> out_data = 4*496 = 1984; 1 output only.
//  - T3 signed/wrap:
//    - All lanes = -1 -> out_data = -32 (0xFFFF_FFE0).
//    - Lanes = 0x7FFF_FFFF, 2 beats -> out_data = (64*0x7FFF_FFFF) mod 2^32 = 0xFFFF_FFC0.
//  - T4 backpressure: hold out_ready=0 for 10 cycles with 3 groups streaming.
//    - in_ready drops and out_data stays stable.
//    - On release, sums of groups 1, 2, 3 exit in order; none lost or duplicated.
//  - T5 reset mid-group: 2 beats of 5 accepted, assert rst 1 cycle, then new single beat of all 2s.
//    - Only output is 64; busy=0 the cycle after reset.
//  - T6 random: 10k beats, random in_valid/out_ready/in_last vs. scoreboard model.

Source files
------------

// File: rtl/pe_acc_pkg.sv
// Shared defaults and elaboration-time helpers for the pipelined PE accumulator.
package pe_acc_pkg;

   localparam int NUM_LANES_DEF = 32;
   localparam int IN_W_DEF      = 32;
   localparam int ACC_W_DEF     = 32;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Low bit index of element j in a flat bus of w-bit elements.
   function automatic int lane_slice(input int j, input int w);
      return w * j;
   endfunction

endpackage

// File: rtl/pe_add_stage.sv
// One registered level of the add tree: N_IN signed operands of width W
// reduced pairwise to N_IN/2 sums of width W+1, with valid and last riding alongside.
module pe_add_stage
   import pe_acc_pkg::*;
#(
   parameter int N_IN = 2,
   parameter int W    = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         in_valid,
   input  logic                         in_last,
   input  logic [N_IN*W-1:0]            in_data,
   output logic                         out_valid,
   output logic                         out_last,
   output logic [(N_IN/2)*(W+1)-1:0]    out_data
);

   localparam int N_OUT = N_IN / 2;
   localparam int OW    = W + 1;

   logic [N_OUT*OW-1:0] sum_p;

   for (genvar j = 0; j < N_OUT; j++) begin : g_pair
      logic signed [W-1:0] a;
      logic signed [W-1:0] b;
      assign a = in_data[lane_slice(2*j, W) +: W];
      assign b = in_data[lane_slice(2*j+1, W) +: W];
      // One bit of growth per level keeps the sum exact.
      assign sum_p[lane_slice(j, OW) +: OW] = OW'(a) + OW'(b);
   end

   // Stage boundary: tree level register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
      end else if (en) begin
         out_valid <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         out_last <= in_last;
         out_data <= sum_p;
      end
   end

endmodule

// File: rtl/pe_acc_pipe.sv
// Pipelined PE reduction: registered binary add tree over NUM_LANES signed
// products, group accumulator terminated by in_last, valid/ready result port.
module pe_acc_pipe
   import pe_acc_pkg::*;
#(
   parameter int NUM_LANES = NUM_LANES_DEF,
   parameter int IN_W      = IN_W_DEF,
   parameter int ACC_W     = ACC_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_LANES*IN_W-1:0] in_data,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACC_W-1:0]          out_data,
   output logic                      busy
);

   localparam int LVL   = clog2(NUM_LANES);
   localparam int SUM_W = IN_W + LVL;

   logic                    stall;
   logic                    en;
   logic [LVL:1]            vld_p;
   logic signed [SUM_W-1:0] tree_sum;
   logic                    tree_last;
   logic signed [ACC_W-1:0] acc_p;
   logic signed [ACC_W-1:0] sum_acc;
   logic signed [ACC_W-1:0] acc_next;
   logic                    acc_open;

   // Truncates or sign-extends the exact tree sum into the wrapping accumulator.
   function automatic logic signed [ACC_W-1:0] fit_acc(input logic signed [SUM_W-1:0] s);
      return ACC_W'(s);
   endfunction

   assign stall    = out_valid & ~out_ready;
   assign en       = ~stall;
   assign in_ready = ~stall & ~rst;

   for (genvar k = 1; k <= LVL; k++) begin : g_lvl
      localparam int NI = NUM_LANES >> (k - 1);
      localparam int WI = IN_W + k - 1;
      logic [(NI/2)*(WI+1)-1:0] data;
      logic                     vld;
      logic                     last;
      if (k == 1) begin : g_src
         pe_add_stage #(.N_IN(NI), .W(WI)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .in_valid  (in_valid & in_ready),
            .in_last   (in_last),
            .in_data   (in_data),
            .out_valid (vld),
            .out_last  (last),
            .out_data  (data)
         );
      end else begin : g_src
         pe_add_stage #(.N_IN(NI), .W(WI)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .in_valid  (vld_p[k-1]),
            .in_last   (g_lvl[k-1].last),
            .in_data   (g_lvl[k-1].data),
            .out_valid (vld),
            .out_last  (last),
            .out_data  (data)
         );
      end
      assign vld_p[k] = vld;
   end

   assign tree_sum  = g_lvl[LVL].data;
   assign tree_last = g_lvl[LVL].last;
   assign sum_acc   = fit_acc(tree_sum);
   assign acc_next  = acc_p + sum_acc;

   // Stage boundary: accumulator and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p     <= '0;
         acc_open  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (en && vld_p[LVL]) begin
            if (tree_last) begin
               out_data  <= acc_next;
               out_valid <= 1'b1;
               acc_p     <= '0;
               acc_open  <= 1'b0;
            end else begin
               acc_p     <= acc_next;
               acc_open  <= 1'b1;
            end
         end
      end
   end

   assign busy = (|vld_p) | acc_open;

endmodule

// File: tb/tb_pe_acc_pipe.sv
// Bench for pe_acc_pipe: directed cases plus randomized traffic against a
// group-sum model computed from the lane values of every accepted beat.
module tb_pe_acc_pipe;

   localparam int NL = 32;
   localparam int IW = 32;
   localparam int AW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [NL*IW-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [AW-1:0]    out_data;
   logic             busy;

   always #5 clk = ~clk;

   pe_acc_pipe #(.NUM_LANES(NL), .IN_W(IW), .ACC_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   int            vectors = 0;
   int            miscompares = 0;
   int            cyc = 0;
   int            n_out = 0;
   int            n0;
   int            hold_cnt = 0;
   int            fire_cyc = 0;
   logic [AW-1:0] exp_q[$];
   longint        acc_m = 0;
   logic [AW-1:0] last_out = '0;
   logic [AW-1:0] hold_data = '0;
   bit            hold_pending = 0;
   bit            lat_arm = 0;
   bit            lat_en = 0;
   bit            saw_drop = 0;
   bit            rand_rdy = 0;
   bit            last_in_fire = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NL*IW-1:0] splat(input logic [IW-1:0] v);
      logic [NL*IW-1:0] d;
      for (int j = 0; j < NL; j++) d[IW*j +: IW] = v;
      return d;
   endfunction

   function automatic logic [NL*IW-1:0] ramp();
      logic [NL*IW-1:0] d;
      for (int j = 0; j < NL; j++) d[IW*j +: IW] = IW'(j);
      return d;
   endfunction

   function automatic logic [NL*IW-1:0] rnd();
      logic [NL*IW-1:0] d;
      for (int j = 0; j < NL; j++) d[IW*j +: IW] = $urandom();
      return d;
   endfunction

   // One clock cycle: set out_ready, sample at negedge+1, update model, advance.
   task automatic cycle();
      bit            in_fire;
      bit            out_fire;
      longint        s;
      logic [AW-1:0] e;
      if (hold_cnt > 0) begin
         out_ready = 1'b0;
         hold_cnt--;
      end else if (rand_rdy) begin
         out_ready = ($urandom_range(0, 3) != 0);
      end else begin
         out_ready = 1'b1;
      end
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready && !rst;
      last_in_fire = in_fire;
      if (rst) begin
         check("rst_in_ready", longint'(in_ready), 0);
         acc_m = 0;
         exp_q.delete();
         hold_pending = 0;
         lat_arm = 0;
      end else begin
         check("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
         if (!in_ready) saw_drop = 1;
         if (hold_pending) begin
            check("valid_held", longint'(out_valid), 1);
            check("data_held", longint'(out_data), longint'(hold_data));
         end
         hold_pending = out_valid && !out_ready;
         hold_data = out_data;
         if (lat_arm && out_valid) begin
            check("latency", longint'(cyc - fire_cyc), 6);
            lat_arm = 0;
         end
         if (out_fire) begin
            check("out_present", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("out_data", longint'(out_data), longint'(e));
            end
            last_out = out_data;
            n_out++;
         end
         if (in_fire) begin
            s = 0;
            for (int j = 0; j < NL; j++) s += longint'($signed(in_data[IW*j +: IW]));
            acc_m += s;
            if (in_last) begin
               exp_q.push_back(acc_m[AW-1:0]);
               acc_m = 0;
               if (lat_en) begin
                  lat_arm = 1;
                  fire_cyc = cyc;
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic send(input logic [NL*IW-1:0] d, input logic l);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      do begin
         cycle();
         t++;
      end while (!last_in_fire && t < 100);
      check("send_accept", longint'(last_in_fire), 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      in_valid = 1'b0;
      while ((exp_q.size() > 0 || busy) && t < 300) begin
         cycle();
         t++;
      end
      for (int i = 0; i < 8; i++) cycle();
      check("drain_empty", longint'(exp_q.size()), 0);
      check("drain_idle", longint'(busy), 0);
   endtask

   initial begin
      int beats;
      int t;
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;
      #1;
      check("reset_out_valid", longint'(out_valid), 0);
      check("reset_out_data", longint'(out_data), 0);
      check("reset_busy", longint'(busy), 0);

      // T1 single beat of ones
      lat_en = 1;
      n0 = n_out;
      send(splat(32'd1), 1'b1);
      drain();
      check("t1_sum", longint'(last_out), 32);
      check("t1_count", longint'(n_out - n0), 1);

      // T2 four beats of lane j = j
      n0 = n_out;
      for (int b = 0; b < 4; b++) begin
         send(ramp(), b == 3);
         if (b == 1) check("t2_busy", longint'(busy), 1);
      end
      drain();
      check("t2_sum", longint'(last_out), 1984);
      check("t2_count", longint'(n_out - n0), 1);
      lat_en = 0;

      // T3 signed and wrapping sums
      send(splat(32'hFFFF_FFFF), 1'b1);
      drain();
      check("t3_neg", longint'(last_out), 64'h0000_0000_FFFF_FFE0);
      send(splat(32'h7FFF_FFFF), 1'b0);
      send(splat(32'h7FFF_FFFF), 1'b1);
      drain();
      check("t3_wrap", longint'(last_out), 64'h0000_0000_FFFF_FFC0);

      // T4 backpressure with three groups in flight
      n0 = n_out;
      saw_drop = 0;
      hold_cnt = 10;
      for (int g = 0; g < 3; g++)
         for (int b = 0; b < 3; b++) send(rnd(), b == 2);
      drain();
      check("t4_in_ready_drop", longint'(saw_drop), 1);
      check("t4_count", longint'(n_out - n0), 3);

      // T5 reset in the middle of a group
      n0 = n_out;
      send(rnd(), 1'b0);
      send(rnd(), 1'b0);
      check("t5_busy_before", longint'(busy), 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      #1;
      check("t5_busy_after", longint'(busy), 0);
      check("t5_valid_after", longint'(out_valid), 0);
      send(splat(32'd2), 1'b1);
      drain();
      check("t5_sum", longint'(last_out), 64);
      check("t5_count", longint'(n_out - n0), 1);

      // T6 randomized traffic
      rand_rdy = 1;
      beats = 0;
      t = 0;
      while (beats < 10000 && t < 60000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_last  = ($urandom_range(0, 3) == 0);
         in_data  = ($urandom_range(0, 15) == 0) ? splat(32'h8000_0000) : rnd();
         cycle();
         if (last_in_fire) beats++;
         t++;
      end
      check("t6_beats", longint'(beats), 10000);
      rand_rdy = 0;
      send(rnd(), 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
